// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: chooses PC select/stall and IF/ID, ID/EXE flushes.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module fetch_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hcf_i,
    input  logic                 load_use_i,
    input  logic                 bp_taken_i,
    input  logic                 exe_valid_i,
    input  logic                 exe_is_br_i,
    input  logic                 exe_pred_taken_i,
    input  logic                 exe_taken_i,
    input  logic                 exe_tgt_ok_i,
    input  logic                 imem_ready_i,
    output logic                 imem_req_o,
    output logic [1:0]           pc_sel_o,
    output logic                 pc_stall_o,
    output logic                 if_flush_o,
    output logic                 id_flush_o,
    output logic                 halted_o,
    output logic [CNT_WIDTH-1:0] mispred_cnt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_t;

    state_t     state_q, state_d;
    logic       pend_q, pend_d;
    logic [1:0] pend_sel_q, pend_sel_d;
    logic       halted_q, halted_d;
    logic       mis;
    logic [1:0] rsel;

    always_comb begin
        mis = exe_valid_i & exe_is_br_i &
              ((exe_pred_taken_i ^ exe_taken_i) | (exe_taken_i & ~exe_tgt_ok_i));
        rsel = exe_taken_i ? 2'd3 : 2'd2;

        state_d    = state_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        pc_sel_o   = 2'd0;
        pc_stall_o = 1'b1;
        if_flush_o = 1'b0;
        id_flush_o = 1'b0;
        imem_req_o = 1'b0;

        case (state_q)
            IDLE: state_d = RUN;
            RUN, WAIT: begin
                imem_req_o = 1'b1;
                if (hcf_i) begin
                    imem_req_o = 1'b0;
                    pend_d     = 1'b0;
                    state_d    = HALT;
                end else if (state_q == WAIT && pend_q) begin
                    // Deferred redirect lands once the wrong-path fetch returns.
                    if (imem_ready_i) begin
                        pc_sel_o   = pend_sel_q;
                        pc_stall_o = 1'b0;
                        if_flush_o = 1'b1;
                        pend_d     = 1'b0;
                        state_d    = RUN;
                    end
                end else if (mis && imem_ready_i) begin
                    pc_sel_o   = rsel;
                    pc_stall_o = 1'b0;
                    if_flush_o = 1'b1;
                    id_flush_o = 1'b1;
                    state_d    = RUN;
                end else if (mis) begin
                    if_flush_o = 1'b1;
                    id_flush_o = 1'b1;
                    pend_d     = 1'b1;
                    pend_sel_d = rsel;
                    state_d    = WAIT;
                end else if (load_use_i) begin
                    id_flush_o = 1'b1;
                    if (imem_ready_i) state_d = RUN;
                end else if (!imem_ready_i) begin
                    state_d = WAIT;
                end else begin
                    pc_sel_o   = bp_taken_i ? 2'd1 : 2'd0;
                    pc_stall_o = 1'b0;
                    state_d    = RUN;
                end
            end
            default: state_d = HALT;
        endcase

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pend_sel_q <= 2'd0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            halted_q   <= halted_d;
        end
    end

    assign halted_o = halted_q;

`ifdef PERF_CNT_EN
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // pc_sel 2/3 is only ever driven when a redirect is applied to the PC.
    always_comb begin
        mispred_cnt_d = pc_sel_o[1] ? sat_inc(mispred_cnt_q) : mispred_cnt_q;
        stall_cnt_d   = (pc_stall_o && (state_q == RUN || state_q == WAIT)) ?
                        sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            mispred_cnt_q <= mispred_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign mispred_cnt_o = mispred_cnt_q;
    assign stall_cnt_o   = stall_cnt_q;
`else
    assign mispred_cnt_o = '0;
    assign stall_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random stimulus against a
// behavioural model of the fetch sequencing rules.
module tb_fetch_ctrl;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, hcf_i, load_use_i, bp_taken_i, exe_valid_i, exe_is_br_i;
    logic exe_pred_taken_i, exe_taken_i, exe_tgt_ok_i, imem_ready_i;
    logic imem_req_o, pc_stall_o, if_flush_o, id_flush_o, halted_o;
    logic [1:0] pc_sel_o;
    logic [CW-1:0] mispred_cnt_o, stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit m_boot, m_halt, m_wait, m_pend;
    int m_psel, m_mcnt, m_scnt;
    // model expectations for the current cycle
    int e_sel;
    bit e_stall, e_if, e_id, e_req;

    fetch_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .hcf_i(hcf_i), .load_use_i(load_use_i),
        .bp_taken_i(bp_taken_i), .exe_valid_i(exe_valid_i), .exe_is_br_i(exe_is_br_i),
        .exe_pred_taken_i(exe_pred_taken_i), .exe_taken_i(exe_taken_i),
        .exe_tgt_ok_i(exe_tgt_ok_i), .imem_ready_i(imem_ready_i),
        .imem_req_o(imem_req_o), .pc_sel_o(pc_sel_o), .pc_stall_o(pc_stall_o),
        .if_flush_o(if_flush_o), .id_flush_o(id_flush_o), .halted_o(halted_o),
        .mispred_cnt_o(mispred_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_wait = 0; m_pend = 0;
        m_psel = 0; m_mcnt = 0; m_scnt = 0;
    endtask

    // Evaluate this cycle's outputs and advance the model one clock edge.
    task automatic model_cycle(input bit advance);
        bit mis, redir, nboot, nhalt, nwait, npend;
        int rs, npsel;
        mis = exe_valid_i && exe_is_br_i &&
              ((exe_pred_taken_i != exe_taken_i) || (exe_taken_i && !exe_tgt_ok_i));
        rs = exe_taken_i ? 3 : 2;
        e_sel = 0; e_stall = 1; e_if = 0; e_id = 0; e_req = 0; redir = 0;
        nboot = m_boot; nhalt = m_halt; nwait = m_wait; npend = m_pend; npsel = m_psel;
        if (m_boot) begin
            nboot = 0;
        end else if (!m_halt) begin
            e_req = 1;
            if (hcf_i) begin
                e_req = 0; nhalt = 1; npend = 0; nwait = 0;
            end else if (m_wait && m_pend) begin
                if (imem_ready_i) begin
                    e_sel = m_psel; e_stall = 0; e_if = 1; npend = 0; nwait = 0; redir = 1;
                end
            end else if (mis && imem_ready_i) begin
                e_sel = rs; e_stall = 0; e_if = 1; e_id = 1; nwait = 0; redir = 1;
            end else if (mis) begin
                e_if = 1; e_id = 1; npend = 1; npsel = rs; nwait = 1;
            end else if (load_use_i) begin
                e_id = 1;
                if (imem_ready_i) nwait = 0;
            end else if (!imem_ready_i) begin
                nwait = 1;
            end else begin
                e_sel = bp_taken_i ? 1 : 0; e_stall = 0; nwait = 0;
            end
        end
        if (advance) begin
            if (redir && m_mcnt < CMAX) m_mcnt++;
            if (!m_boot && !m_halt && e_stall && m_scnt < CMAX) m_scnt++;
            m_boot = nboot; m_halt = nhalt; m_wait = nwait; m_pend = npend; m_psel = npsel;
        end
    endtask

    task automatic cyc(input bit r, input bit hcf, input bit lu, input bit bp,
                       input bit ev, input bit eb, input bit ep, input bit et,
                       input bit eo, input bit rdy);
        @(negedge clk);
        rst = r; hcf_i = hcf; load_use_i = lu; bp_taken_i = bp;
        exe_valid_i = ev; exe_is_br_i = eb; exe_pred_taken_i = ep;
        exe_taken_i = et; exe_tgt_ok_i = eo; imem_ready_i = rdy;
        if (r) model_reset();
        #1;
        model_cycle(1'b0);
        check("pc_sel", pc_sel_o, e_sel);
        check("pc_stall", pc_stall_o, e_stall);
        check("if_flush", if_flush_o, e_if);
        check("id_flush", id_flush_o, e_id);
        check("imem_req", imem_req_o, e_req);
        check("halted", halted_o, m_halt);
`ifdef PERF_CNT_EN
        check("mispred_cnt", mispred_cnt_o, m_mcnt);
        check("stall_cnt", stall_cnt_o, m_scnt);
`else
        check("mispred_cnt", mispred_cnt_o, 0);
        check("stall_cnt", stall_cnt_o, 0);
`endif
        if (!r) model_cycle(1'b1);
    endtask

    task automatic idle_run(input bit rdy);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, rdy);
    endtask

    initial begin
        rst = 1; hcf_i = 0; load_use_i = 0; bp_taken_i = 0; exe_valid_i = 0;
        exe_is_br_i = 0; exe_pred_taken_i = 0; exe_taken_i = 0; exe_tgt_ok_i = 1;
        imem_ready_i = 1;
        model_reset();

        // reset, IDLE, then RUN
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("rst_halted", halted_o, 0);
        idle_run(1);
        check("idle_stall", pc_stall_o, 1);
        check("idle_req", imem_req_o, 0);
        idle_run(1);
        check("run_sel", pc_sel_o, 0);
        check("run_stall", pc_stall_o, 0);

        // mispredict (pred not-taken, actually taken) with fetch ready
        cyc(0, 0, 0, 0, 1, 1, 0, 1, 1, 1);
        check("mis_sel", pc_sel_o, 3);
        check("mis_ifl", if_flush_o, 1);
        check("mis_idl", id_flush_o, 1);
        idle_run(1);
`ifdef PERF_CNT_EN
        check("mis_cnt", mispred_cnt_o, 1);
`endif

        // deferred redirect across 3 not-ready cycles
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle_run(1);
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
        check("def_stall0", pc_stall_o, 1);
        idle_run(0);
        check("def_stall1", pc_stall_o, 1);
        idle_run(0);
        check("def_stall2", pc_stall_o, 1);
        idle_run(1);
        check("def_sel", pc_sel_o, 2);
        check("def_ifl", if_flush_o, 1);
        check("def_stall", pc_stall_o, 0);
`ifdef PERF_CNT_EN
        check("def_scnt", stall_cnt_o, 3);
`endif
        idle_run(1);
        check("def_clear", pc_sel_o, 0);

        // load-use, then predicted-taken
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 1, 1);
        check("lu_stall", pc_stall_o, 1);
        check("lu_idl", id_flush_o, 1);
        check("lu_ifl", if_flush_o, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        check("bp_sel", pc_sel_o, 1);

        // halt beats a same-cycle mispredict
        cyc(0, 1, 0, 0, 1, 1, 0, 1, 1, 1);
        check("hcf_ifl", if_flush_o, 0);
        check("hcf_idl", id_flush_o, 0);
        check("hcf_stall", pc_stall_o, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, $urandom_range(0, 1), 1, 1, 1, 0, 1, 1, 1);
            check("halt_h", halted_o, 1);
            check("halt_req", imem_req_o, 0);
        end

        // counter saturation over 20 stall cycles
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle_run(1);
        for (int i = 0; i < 20; i++) idle_run(0);
`ifdef PERF_CNT_EN
        check("sat_scnt", stall_cnt_o, CMAX);
`endif
        idle_run(1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
            if (m_halt && $urandom_range(0, 7) == 0)
                cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
